mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV64 core. Sits directly downstream of `exe_stage` and upstream of `regfile`'s write port. Executes loads and stores over a request/acknowledge data-memory port, and aligns and sign/zero-extends load data. Passes non-memory ALU results through to writeback with one register stage, and stalls upstream while a memory access is outstanding.

## Interface

Parameters: none. Data width is `REG_BUS` (64 bits).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: `ex_*` inputs carry a valid instruction this cycle.
- `ex_mem_rd` in 1: instruction is a load.
- `ex_mem_wr` in 1: instruction is a store. Never set together with `ex_mem_rd`.
- `ex_funct3` in 3: access size and sign.
  - Loads: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - Stores use bits [1:0] only.
- `ex_addr` in 64: effective address from the ALU.
- `ex_wdata` in 64: store data (rs2), right-aligned.
- `ex_alu_result` in 64: result for non-memory instructions.
- `ex_rd_addr` in 5, `ex_rd_w_ena` in 1: destination register and write enable.
- `mem_stall` out 1: combinational; upstream holds all `ex_*` inputs while high.
- `dmem_req` out 1, `dmem_we` out 1: data-memory request and write flag.
- `dmem_addr` out 64: doubleword-aligned address, `{ex_addr[63:3],3'b0}`.
- `dmem_wdata` out 64, `dmem_wmask` out 8: lane-shifted store data and byte mask.
- `dmem_ack` in 1: request completes this cycle; `dmem_rdata` is valid.
- `dmem_rdata` in 64: doubleword read data.
- `wb_valid` out 1, `wb_rd_w_ena` out 1, `wb_rd_addr` out 5, `wb_rd_data` out 64: registered writeback.
- `misalign_exc` out 1, `misalign_addr` out 64: registered one-cycle misalignment report.

## Operation

- States: IDLE, WAIT.
- The access is accepted in IDLE when `ex_valid & (ex_mem_rd|ex_mem_wr) & aligned`.
  - The block latches addr, funct3, wdata, rd and rd enable.
  - State goes to WAIT.
- In WAIT:
  - `dmem_req=1`; address, we, wdata and wmask are driven from the latched values and stay stable until ack.
  - On `dmem_ack`, load data is captured into the writeback registers, `wb_valid=1` is set next cycle, and state returns to IDLE.
- `mem_stall = ex_valid & is_mem & aligned & !(state==WAIT & dmem_ack)`. The upstream stage advances on the ack edge.
- Alignment:
  - byte: always aligned
  - half: `addr[0]==0`
  - word: `addr[1:0]==0`
  - double: `addr[2:0]==0`
- Misaligned access:
  - No request is issued and there is no stall.
  - Next cycle: `misalign_exc=1`, `misalign_addr=ex_addr`, `wb_valid=0`.
- Store lanes, with `lane=addr[2:0]`:
  - `dmem_wmask = {1,3,F,FF}[size] << lane`
  - `dmem_wdata = ex_wdata << (8*lane)`
- Load extract: `rdata >> (8*lane)`, truncated to size. `funct3[2]=0` sign-extends and `funct3[2]=1` zero-extends to 64 bits.
- Non-memory instruction (`ex_valid` and not a memory op, in IDLE): next cycle `wb_valid=1` and `wb_rd_data=ex_alu_result`.
- Stores: `wb_valid=1` on completion with `wb_rd_w_ena=0`.
- `wb_rd_w_ena = rd_w_ena & (rd_addr!=0)`.
- In IDLE, `dmem_ack` is ignored; a stray or late ack has no effect.

## Timing

- Reset values (async, immediate): state=IDLE; all outputs 0 (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wmask`, `wb_*`, `misalign_*`).
- `mem_stall` follows its equation, so it is 0 whenever `ex_valid` is 0.
- Non-memory latency: 1 cycle, input at T → `wb_valid` at T+1.
- Memory latency: accept at T; `dmem_req` from T+1; ack at T+k (k≥1); `wb_valid` at T+k+1.
  - `mem_stall` is high for T..T+k-1.
  - Minimum is 2 cycles, 1 stall cycle.
- `wb_valid` and `misalign_exc` are single-cycle pulses per instruction.
- Reset mid-access (WAIT): `dmem_req` drops asynchronously, no writeback occurs, and the in-flight ack is ignored.
- While the block is in WAIT, `ex_*` are held by upstream; no new instruction is accepted until the cycle after the ack edge.

## Test plan

- ALU pass-through: `ex_valid=1`, non-mem, rd=5, result=0x1234 → next cycle `wb_valid=1`, `wb_rd_addr=5`, `wb_rd_data=0x1234`, `mem_stall` never high.
- LB sign-extension: addr=0x1003, `dmem_rdata=0x00000000_80000000`, ack 3 cycles after req → `dmem_addr=0x1000`, `mem_stall` high 3 cycles, `wb_rd_data=0xFFFFFFFF_FFFFFF80`. Repeat with LBU → `0x80`.
- SH at addr=0x2006, wdata=0xBEEF → `dmem_we=1`, `dmem_wmask=0xC0`, `dmem_wdata[63:48]=0xBEEF`, `wb_valid=1` with `wb_rd_w_ena=0` after ack.
- Misaligned LW at 0x3002 → no `dmem_req`, no stall, next cycle `misalign_exc=1` and `misalign_addr=0x3002`.
- LD with `rst` asserted in WAIT before ack → `dmem_req=0` immediately; ack delivered after reset release → no `wb_valid`.
- Back-to-back: LD (ack k=1) followed by ALU op → `wb_valid` on two consecutive cycles, no lost or duplicated writeback; load to rd=0 → `wb_rd_w_ena=0`.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack data port, aligns
// load data, and registers ALU results and load data into writeback.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [2:0]  ex_funct3,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [63:0] ex_alu_result,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_w_ena,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_rd_w_ena,
  output logic [4:0]  wb_rd_addr,
  output logic [63:0] wb_rd_data,
  output logic        misalign_exc,
  output logic [63:0] misalign_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic [2:0]  lat_funct3;
  logic [2:0]  lat_lane;
  logic        lat_we;
  logic        lat_rd_ena;
  logic [4:0]  lat_rd_addr;

  logic        is_mem;
  logic        aligned;
  logic        in_idle;
  logic        accept;
  logic        misaligned;
  logic        alu_pass;
  logic        ack_done;
  logic [7:0]  size_mask;
  logic [7:0]  st_mask;
  logic [63:0] st_wdata;
  logic [63:0] ld_shift;
  logic [63:0] ld_data;

  assign is_mem     = ex_mem_rd | ex_mem_wr;
  assign in_idle    = (state == IDLE);
  assign accept     = in_idle & ex_valid & is_mem & aligned;
  assign misaligned = in_idle & ex_valid & is_mem & ~aligned;
  assign alu_pass   = in_idle & ex_valid & ~is_mem;
  assign ack_done   = (state == WAIT) & dmem_ack;

  // Upstream advances on the ack edge, so stall drops in the ack cycle.
  assign mem_stall  = ex_valid & is_mem & aligned & ~ack_done;

  assign dmem_req   = (state == WAIT);
  assign dmem_we    = dmem_req & lat_we;

  always_comb begin
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (ex_funct3[1:0])
      2'b00: begin aligned = 1'b1;                 size_mask = 8'h01; end
      2'b01: begin aligned = ~ex_addr[0];          size_mask = 8'h03; end
      2'b10: begin aligned = (ex_addr[1:0] == '0); size_mask = 8'h0F; end
      default: begin aligned = (ex_addr[2:0] == '0); size_mask = 8'hFF; end
    endcase
  end

  assign st_mask  = size_mask << ex_addr[2:0];
  assign st_wdata = ex_wdata << {ex_addr[2:0], 3'b000};

  assign ld_shift = dmem_rdata >> {lat_lane, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (lat_funct3)
      3'b000:  ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_data = {56'd0, ld_shift[7:0]};
      3'b101:  ld_data = {48'd0, ld_shift[15:0]};
      3'b110:  ld_data = {32'd0, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_funct3  <= '0;
      lat_lane    <= '0;
      lat_we      <= 1'b0;
      lat_rd_ena  <= 1'b0;
      lat_rd_addr <= '0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= WAIT;
            lat_funct3  <= ex_funct3;
            lat_lane    <= ex_addr[2:0];
            lat_we      <= ex_mem_wr;
            lat_rd_ena  <= ex_rd_w_ena;
            lat_rd_addr <= ex_rd_addr;
            dmem_addr   <= {ex_addr[63:3], 3'b000};
            dmem_wdata  <= ex_mem_wr ? st_wdata : '0;
            dmem_wmask  <= ex_mem_wr ? st_mask : '0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_rd_w_ena   <= 1'b0;
      wb_rd_addr    <= '0;
      wb_rd_data    <= '0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid     <= 1'b0;
      wb_rd_w_ena  <= 1'b0;
      misalign_exc <= misaligned;
      if (misaligned) begin
        misalign_addr <= ex_addr;
      end
      if (ack_done) begin
        wb_valid    <= 1'b1;
        wb_rd_w_ena <= ~lat_we & lat_rd_ena & (lat_rd_addr != '0);
        wb_rd_addr  <= lat_rd_addr;
        wb_rd_data  <= lat_we ? '0 : ld_data;
      end else if (alu_pass) begin
        wb_valid    <= 1'b1;
        wb_rd_w_ena <= ex_rd_w_ena & (ex_rd_addr != '0);
        wb_rd_addr  <= ex_rd_addr;
        wb_rd_data  <= ex_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected writeback/exception
// events, a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata, ex_alu_result;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_w_ena;
  logic        mem_stall, dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_rd_w_ena;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic        misalign_exc;
  logic [63:0] misalign_addr;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu_result(ex_alu_result), .ex_rd_addr(ex_rd_addr), .ex_rd_w_ena(ex_rd_w_ena),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd_w_ena(wb_rd_w_ena), .wb_rd_addr(wb_rd_addr),
    .wb_rd_data(wb_rd_data), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    bit          ena;
    bit          chk_data;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference load: pick bytes out of the doubleword, then extend.
  function automatic logic [63:0] load_val(logic [2:0] f3, logic [2:0] lane, logic [63:0] rd);
    int unsigned nb = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int unsigned i = 0; i < nb; i++)
      v[8*i +: 8] = rd[8*(int'(lane)+i) +: 8];
    if (!f3[2] && v[8*nb-1])
      for (int unsigned i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] store_mask(logic [1:0] sz, logic [2:0] lane);
    logic [7:0] m = '0;
    for (int unsigned i = 0; i < (1 << sz); i++) m[int'(lane)+i] = 1'b1;
    return m;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (wb_valid || misalign_exc)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(1), 64'(0));
      end else begin
        mon_e = q.pop_front();
        chk("misalign_exc", 64'(misalign_exc), 64'(mon_e.mis));
        chk("wb_valid", 64'(wb_valid), 64'(!mon_e.mis));
        if (mon_e.mis) begin
          chk("misalign_addr", misalign_addr, mon_e.data);
        end else begin
          chk("wb_rd_w_ena", 64'(wb_rd_w_ena), 64'(mon_e.ena));
          if (mon_e.chk_data) begin
            chk("wb_rd_addr", 64'(wb_rd_addr), 64'(mon_e.rd));
            chk("wb_rd_data", wb_rd_data, mon_e.data);
          end
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that completes it.
  task automatic do_instr(bit v, bit rd_op, bit wr_op, logic [2:0] f3, logic [63:0] addr,
                          logic [63:0] wdata, logic [63:0] alu, logic [4:0] rd, bit ena,
                          int k, logic [63:0] rdata, bit stray);
    exp_t e;
    bit is_mem, al;
    int unsigned nb;
    ex_valid = v; ex_mem_rd = rd_op; ex_mem_wr = wr_op; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_alu_result = alu;
    ex_rd_addr = rd; ex_rd_w_ena = ena;
    is_mem = rd_op || wr_op;
    nb = 1 << f3[1:0];
    al = (addr % nb) == 0;
    if (!v) begin
      dmem_ack = stray; dmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_stall", 64'(mem_stall), 64'(0));
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end else if (!is_mem) begin
      e = '{mis: 0, ena: ena && rd != 0, chk_data: 1, rd: rd, data: alu};
      q.push_back(e);
      @(negedge clk);
      chk("alu_stall", 64'(mem_stall), 64'(0));
      @(posedge clk); #1;
    end else if (!al) begin
      e = '{mis: 1, ena: 0, chk_data: 0, rd: '0, data: addr};
      q.push_back(e);
      @(negedge clk);
      chk("mis_stall", 64'(mem_stall), 64'(0));
      chk("mis_req", 64'(dmem_req), 64'(0));
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      chk("acc_stall", 64'(mem_stall), 64'(1));
      chk("acc_req", 64'(dmem_req), 64'(0));
      @(posedge clk); #1;
      for (int j = 1; j <= k; j++) begin
        dmem_ack = (j == k);
        dmem_rdata = (j == k) ? rdata : {$urandom, $urandom};
        if (j == k) begin
          if (wr_op) e = '{mis: 0, ena: 0, chk_data: 0, rd: rd, data: '0};
          else e = '{mis: 0, ena: ena && rd != 0, chk_data: 1, rd: rd,
                     data: load_val(f3, addr[2:0], rdata)};
          q.push_back(e);
        end
        @(negedge clk);
        chk("dmem_req", 64'(dmem_req), 64'(1));
        chk("dmem_addr", dmem_addr, {addr[63:3], 3'b000});
        chk("dmem_we", 64'(dmem_we), 64'(wr_op));
        if (wr_op) begin
          chk("dmem_wmask", 64'(dmem_wmask), 64'(store_mask(f3[1:0], addr[2:0])));
          chk("dmem_wdata", dmem_wdata, wdata << (8 * addr[2:0]));
        end
        chk("wait_stall", 64'(mem_stall), 64'(j < k));
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
    end
    ex_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int kind;
    logic [2:0] f3;
    rst = 1'b1; ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_funct3 = 0;
    ex_addr = 0; ex_wdata = 0; ex_alu_result = 0; ex_rd_addr = 0; ex_rd_w_ena = 0;
    dmem_ack = 0; dmem_rdata = 0;
    #2;
    chk("rst_req", 64'(dmem_req), 0);
    chk("rst_we", 64'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wmask", 64'(dmem_wmask), 0);
    chk("rst_wb", {wb_valid, wb_rd_w_ena, wb_rd_addr, misalign_exc}, 0);
    chk("rst_wb_data", wb_rd_data, 0);
    chk("rst_mis_addr", misalign_addr, 0);
    chk("rst_stall", 64'(mem_stall), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_instr(1, 0, 0, 3'b000, 64'h0, 0, 64'h1234, 5'd5, 1, 1, 0, 0);
    do_instr(1, 1, 0, 3'b000, 64'h1003, 0, 0, 5'd7, 1, 3, 64'h00000000_80000000, 0);
    do_instr(1, 1, 0, 3'b100, 64'h1003, 0, 0, 5'd7, 1, 3, 64'h00000000_80000000, 0);
    do_instr(1, 0, 1, 3'b001, 64'h2006, 64'hBEEF, 0, 5'd9, 1, 2, 0, 0);
    do_instr(1, 1, 0, 3'b010, 64'h3002, 0, 0, 5'd3, 1, 1, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // Reset while waiting for an ack
    ex_valid = 1; ex_mem_rd = 1; ex_mem_wr = 0; ex_funct3 = 3'b011;
    ex_addr = 64'h4000; ex_rd_addr = 5'd4; ex_rd_w_ena = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 64'(dmem_req), 1);
    #1 rst = 1'b1;
    #1 chk("rst_mid_req", 64'(dmem_req), 0);
    ex_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1; dmem_rdata = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    chk("rst_mid_stall", 64'(mem_stall), 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    chk("rst_mid_no_wb", 64'(wb_valid), 0);
    @(posedge clk); #1;

    // Back-to-back: LD to x0 with k=1, then ALU op
    do_instr(1, 1, 0, 3'b011, 64'h5008, 0, 0, 5'd0, 1, 1, 64'h0123_4567_89AB_CDEF, 0);
    do_instr(1, 0, 0, 3'b000, 0, 0, 64'h5555, 5'd12, 1, 1, 0, 0);

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = '0;
      if (kind == 2) f3 = 3'($urandom_range(0, 6));
      else f3 = {1'b0, 2'($urandom_range(0, 3))};
      do_instr(kind != 0, kind == 2, kind == 3, f3, a, {$urandom, $urandom},
               {$urandom, $urandom}, 5'($urandom), 1'($urandom),
               $urandom_range(1, 4), {$urandom, $urandom}, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
